mul16_seq: RTL

- Sequential 16x16 shift-and-add multiplier controller. It reuses one adder16bit instance as its only adder and sequences it over up to 16 cycles.
- Returns the low 16 bits of the product. This result is identical for signed and unsigned two's-complement operands.
- Sits beside the ALU and serves the MUL instruction. A start/busy/done handshake lets the core stall while the multiply runs.

---
 rtl/mul16_seq_pkg.sv | 13 +
 rtl/mul16_seq_adder16bit.sv | 13 +
 rtl/mul16_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/mul16_seq_pkg.sv
// Shared constants and state encoding for the sequential 16x16 multiplier.
package mul16_seq_pkg;

  localparam int MUL_W     = 16;
  localparam int MUL_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul16_seq_adder16bit.sv
// Plain 16-bit adder reused by the multiplier for every accumulate step.
module adder16bit
  import mul16_seq_pkg::*;
(
  input  logic [MUL_W-1:0] x,
  input  logic [MUL_W-1:0] y,
  output logic [MUL_W-1:0] sum
);

  // Modulo-2^16 sum: the carry out of bit 15 is intentionally dropped.
  assign sum = x + y;

endmodule

// File: rtl/mul16_seq.sv
// Shift-and-add multiplier returning the low 16 bits of a*b over up to 16 cycles,
// with a start/busy/done handshake for stalling the core during MUL.
module mul16_seq
  import mul16_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [MUL_W-1:0] product
);

  state_t                 state_r, state_next_s;
  logic [MUL_W-1:0]       mcand_r, mplier_r, acc_r, product_r;
  logic [MUL_CNT_W-1:0]   count_r;
  logic                   busy_r, done_r;
  logic                   load_s, step_s, prod_load_s, run_exit_s;
  logic [MUL_W-1:0]       prod_val_s, addend_s, sum_s, mplier_shift_s;

  assign addend_s       = mplier_r[0] ? mcand_r : 16'd0;
  assign mplier_shift_s = mplier_r >> 1;
  assign run_exit_s     = (count_r == {MUL_CNT_W{1'b1}}) ||
                          (EARLY_EXIT && (mplier_shift_s == 16'd0));

  adder16bit u_add (
    .x   (acc_r),
    .y   (addend_s),
    .sum (sum_s)
  );

  // Next-state decode plus the load/step/product-capture strobes.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    prod_load_s  = 1'b0;
    prod_val_s   = sum_s;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_s = 1'b1;
          if (EARLY_EXIT && (b == 16'd0)) begin
            // Zero multiplier needs no RUN cycles at all.
            state_next_s = S_DONE;
            prod_load_s  = 1'b1;
            prod_val_s   = 16'd0;
          end else begin
            state_next_s = S_RUN;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        step_s = 1'b1;
        if (run_exit_s) begin
          state_next_s = S_DONE;
          prod_load_s  = 1'b1;
        end else begin
          state_next_s = S_RUN;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      mcand_r   <= 16'd0;
      mplier_r  <= 16'd0;
      acc_r     <= 16'd0;
      count_r   <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= 16'd0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == S_RUN);
      done_r  <= (state_next_s == S_DONE);
      if (load_s) begin
        mcand_r  <= a;
        mplier_r <= b;
        acc_r    <= 16'd0;
        count_r  <= 4'd0;
      end else if (step_s) begin
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_shift_s;
        acc_r    <= sum_s;
        count_r  <= count_r + 4'd1;
      end else begin
        mcand_r  <= mcand_r;
        mplier_r <= mplier_r;
        acc_r    <= acc_r;
        count_r  <= count_r;
      end
      if (prod_load_s) begin
        product_r <= prod_val_s;
      end else begin
        product_r <= product_r;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule
